// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser; line lags FSM by one cycle.
// Writes at full are dropped (the register bank flags them); the FIFO only drains while the divisor is non-zero.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_wr,
  input  logic [DATA_WIDTH-1:0] mdr,
  input  logic [DATA_WIDTH-1:0] dll,
  input  logic [DATA_WIDTH-1:0] dlh,
  input  logic [DATA_WIDTH-1:0] lcr,
  input  logic [DATA_WIDTH-1:0] ier,
  output logic                  uart_tx,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  tx_busy,
  output logic                  tx_int
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DVW = 2 * DATA_WIDTH;
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [DVW-1:0] DIV_ONE  = DVW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [AW:0]           r_count;
  logic [DVW-1:0]        r_div, r_pre;
  logic [3:0]            r_ovs, r_osr_m1;
  logic [1:0]            r_wl;
  logic                  r_par_en, r_even, r_stick, r_stop2, r_stop_idx;
  logic [2:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par, r_tx, r_int;

  logic [DVW-1:0] w_div;
  logic           w_wr_ok, w_pop, w_can_start, w_pre_wrap, w_bit_end, w_line, w_par_bit;
  logic [2:0]     w_last_idx;
  logic           w_unused;

  assign w_div       = {dlh, dll};
  assign w_wr_ok     = tx_wr & ~tx_full;
  assign w_can_start = (r_count != '0) && (w_div != '0);
  assign w_pre_wrap  = (r_pre == r_div - DIV_ONE);
  assign w_bit_end   = w_pre_wrap && (r_ovs == r_osr_m1);
  assign w_last_idx  = 3'd4 + {1'b0, r_wl};
  assign w_par_bit   = r_stick ? ~r_even : (r_even ? r_par : ~r_par);
  assign w_unused    = ^{mdr[DATA_WIDTH-1:1], lcr[DATA_WIDTH-1], ier[DATA_WIDTH-1:2], ier[0]};

  assign tx_full  = (r_count == CNT_FULL);
  assign tx_empty = (r_count == '0);
  assign tx_busy  = (r_state != S_IDLE);
  assign uart_tx  = r_tx;
  assign tx_int   = r_int;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && (r_idx == w_last_idx)) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_line = w_par_bit;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Next frame chains straight into its start bit with no idle gap.
        if (w_bit_end && (r_stop_idx == r_stop2)) begin
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= tx_wdata;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_div      <= '0;
      r_pre      <= '0;
      r_ovs      <= '0;
      r_osr_m1   <= 4'd15;
      r_wl       <= '0;
      r_par_en   <= 1'b0;
      r_even     <= 1'b0;
      r_stick    <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_int      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // Every state lasts whole bit periods, so a bit end leaves both counters at 0 for the next state.
      if (r_state == S_IDLE || w_bit_end) begin
        r_pre <= '0;
        r_ovs <= '0;
      end else if (w_pre_wrap) begin
        r_pre <= '0;
        r_ovs <= r_ovs + 4'd1;
      end else begin
        r_pre <= r_pre + DIV_ONE;
      end

      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_div      <= w_div;
        r_osr_m1   <= mdr[0] ? 4'd12 : 4'd15;
        r_wl       <= lcr[1:0];
        r_stop2    <= lcr[2];
        r_par_en   <= lcr[3];
        r_even     <= lcr[4];
        r_stick    <= lcr[5];
        r_idx      <= '0;
        r_par      <= 1'b0;
        r_stop_idx <= 1'b0;
      end else if (w_bit_end && r_state == S_DATA) begin
        r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        r_par   <= r_par ^ r_shift[0];
        r_idx   <= r_idx + 3'd1;
      end else if (w_bit_end && r_state == S_STOP) begin
        r_stop_idx <= 1'b1;
      end

      r_tx  <= lcr[6] ? 1'b0 : w_line;
      r_int <= ier[1] & tx_empty & ~tx_busy;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: writes push expected frames, a line monitor decodes and compares.
module tb_uart_tx_engine;

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic [7:0] tx_wdata = '0;
  logic       tx_wr = 1'b0;
  logic [7:0] mdr = '0, dll = '0, dlh = '0, lcr = '0, ier = '0;
  logic       uart_tx, tx_full, tx_empty, tx_busy, tx_int;

  uart_tx_engine #(.FIFO_DEPTH(16), .DATA_WIDTH(8)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .tx_wdata(tx_wdata), .tx_wr(tx_wr),
    .mdr(mdr), .dll(dll), .dlh(dlh), .lcr(lcr), .ier(ier),
    .uart_tx(uart_tx), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .tx_int(tx_int)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] d;
    logic [7:0] lcr;
    int         period;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  bit   mon_busy = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Expected line levels of one frame, one entry per bit, built from the frame-format rules.
  function automatic int build(input exp_t e, output logic [11:0] bits);
    int   wl, n, ones;
    logic p;
    wl   = 5 + int'(e.lcr[1:0]);
    bits = '1;
    bits[0] = 1'b0;
    n    = 1;
    ones = 0;
    for (int i = 0; i < wl; i++) begin
      bits[n] = e.d[i];
      ones += int'(e.d[i]);
      n++;
    end
    if (e.lcr[3]) begin
      if (e.lcr[5])      p = ~e.lcr[4];
      else if (e.lcr[4]) p = (ones % 2) == 1;
      else               p = (ones % 2) == 0;
      bits[n] = p;
      n++;
    end
    n += e.lcr[2] ? 2 : 1;
    return n;
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [11:0] bits;
    int          n, bad, last_end;
    logic        badv;
    bit          expect_b2b;
    last_end   = 0;
    expect_b2b = 1'b0;
    forever begin
      @(negedge PCLK);
      if (mon_en && PRESETN === 1'b1 && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: line low at cycle %0d, expected idle high", cyc);
          for (int w = 0; w < 2000 && uart_tx !== 1'b1; w++) @(negedge PCLK);
        end else begin
          e = exp_q.pop_front();
          if (expect_b2b) chki("b2b_start_cycle", cyc, last_end + 1);
          n = build(e, bits);
          for (int b = 0; b < n; b++) begin
            bad  = 0;
            badv = 1'b0;
            for (int c = 0; c < e.period; c++) begin
              if (b != 0 || c != 0) @(negedge PCLK);
              if (uart_tx !== bits[b]) begin
                bad++;
                badv = uart_tx;
              end
            end
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame_bit: data %h bit %0d got %b expected %b (%0d cycles wrong)",
                       e.d, b, badv, bits[b], bad);
            end
          end
          last_end   = cyc;
          expect_b2b = (exp_q.size() != 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit accept, input logic [7:0] el, input int per);
    exp_t e;
    tx_wdata = d;
    tx_wr    = 1'b1;
    if (accept) begin
      e.d      = d;
      e.lcr    = el;
      e.period = per;
      exp_q.push_back(e);
    end
    @(negedge PCLK);
    tx_wr = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_busy) && t < budget) begin
      @(negedge PCLK);
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames outstanding after %0d cycles, required 0", name, exp_q.size(), t);
    end
    repeat (2) @(negedge PCLK);
  endtask

  initial begin : stim
    int         bad, k, dv;
    bit         seen_busy, m;
    logic [7:0] l;

    // Reset: tx_int held 0 on reset edges even with the interrupt enabled.
    ier = 8'h02; lcr = 8'h03; mdr = 8'h00; dll = 8'h00; dlh = 8'h00;
    PRESETN = 1'b0;
    @(negedge PCLK);
    chk1("rst_tx_int", tx_int, 1'b0);
    chk1("rst_uart_tx", uart_tx, 1'b1);
    chk1("rst_full", tx_full, 1'b0);
    chk1("rst_empty", tx_empty, 1'b1);
    chk1("rst_busy", tx_busy, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    chk1("int_after_release", tx_int, 1'b1);

    // 8N1, div=1, 16x: latency and alternating pattern.
    dll = 8'h01;
    @(negedge PCLK);
    wr(8'h55, 1'b1, 8'h03, 16);
    chk1("lat_n_empty", tx_empty, 1'b0);
    chk1("lat_n_busy", tx_busy, 1'b0);
    @(negedge PCLK);
    chk1("lat_n1_empty", tx_empty, 1'b1);
    chk1("lat_n1_busy", tx_busy, 1'b1);
    chk1("lat_n1_line", uart_tx, 1'b1);
    chk1("lat_n1_int", tx_int, 1'b0);
    @(negedge PCLK);
    chk1("lat_n2_line", uart_tx, 1'b0);
    drain("8n1", 400);
    chk1("int_after_8n1", tx_int, 1'b1);

    // 7E2, div=3, 13x.
    dll = 8'h03; mdr = 8'h01; lcr = 8'h1E;
    @(negedge PCLK);
    wr(8'h41, 1'b1, 8'h1E, 39);
    drain("7e2", 1000);

    // Fill at div=0, drop at full, drop at full with a simultaneous pop, then drain back-to-back.
    dll = 8'h00; mdr = 8'h00; lcr = 8'h03;
    @(negedge PCLK);
    for (int i = 0; i < 16; i++) begin
      wr(8'($urandom), 1'b1, 8'h03, 16);
      if (i == 14) chk1("full_at_15", tx_full, 1'b0);
    end
    chk1("full_at_16", tx_full, 1'b1);
    chk1("div0_idle", tx_busy, 1'b0);
    wr(8'hA5, 1'b0, 8'h00, 0);
    chk1("full_after_drop", tx_full, 1'b1);
    dll = 8'h01;
    wr(8'hEE, 1'b0, 8'h00, 0);
    chk1("full_drop_with_pop", tx_full, 1'b0);
    chk1("pop_at_full_busy", tx_busy, 1'b1);
    drain("full", 4000);

    // Write racing the first pop, then a word-length change mid-frame.
    wr(8'hC3, 1'b1, 8'h03, 16);
    wr(8'h3C, 1'b1, 8'h00, 16);
    chk1("race_not_empty", tx_empty, 1'b0);
    chk1("race_busy", tx_busy, 1'b1);
    repeat (30) @(negedge PCLK);
    lcr = 8'h00;
    drain("midframe", 1000);
    lcr = 8'h03;

    // Break at idle and across a whole frame.
    mon_en = 1'b0;
    lcr = 8'h43;
    @(negedge PCLK);
    chk1("break_idle_line", uart_tx, 1'b0);
    wr(8'hFF, 1'b0, 8'h00, 0);
    bad = 0;
    seen_busy = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (uart_tx !== 1'b0) bad++;
      if (tx_busy) seen_busy = 1'b1;
      if (seen_busy && !tx_busy) break;
      @(negedge PCLK);
    end
    chki("break_line_high_cycles", bad, 0);
    chk1("break_fsm_completes", seen_busy && !tx_busy, 1'b1);
    lcr = 8'h03;
    @(negedge PCLK);
    chk1("break_release_line", uart_tx, 1'b1);
    repeat (3) @(negedge PCLK);

    // Reset during the data bits.
    wr(8'h00, 1'b0, 8'h00, 0);
    wr(8'hFF, 1'b0, 8'h00, 0);
    repeat (35) @(negedge PCLK);
    chk1("pre_reset_busy", tx_busy, 1'b1);
    PRESETN = 1'b0;
    @(negedge PCLK);
    chk1("midrst_line", uart_tx, 1'b1);
    chk1("midrst_empty", tx_empty, 1'b1);
    chk1("midrst_busy", tx_busy, 1'b0);
    chk1("midrst_full", tx_full, 1'b0);
    chk1("midrst_int", tx_int, 1'b0);
    PRESETN = 1'b1;
    bad = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge PCLK);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chki("post_reset_residual_cycles", bad, 0);
    mon_en = 1'b1;

    // Randomised frame formats, divisors and oversampling.
    for (int it = 0; it < 12; it++) begin
      l   = 8'($urandom_range(0, 63));
      dv  = $urandom_range(1, 2);
      m   = 1'($urandom_range(0, 1));
      k   = $urandom_range(1, 4);
      lcr = l;
      dll = 8'(dv);
      mdr = {7'($urandom), m};
      ier = 8'($urandom);
      @(negedge PCLK);
      for (int j = 0; j < k; j++) wr(8'($urandom), 1'b1, l, dv * (m ? 13 : 16));
      drain("rand", 6000);
      chk1("rand_int", tx_int, ier[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
